// File: rtl/deserialize.sv
// Serial-in/parallel-out receiver: assembles WIDTH-bit words MSB-first while the
// framing line is high and hands each word to a consumer over a valid/ack handshake.
module deserialize #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 2
) (
  input  logic             input_input_switch1_clock_1,
  input  logic             input_input_switch2_reset_2,
  input  logic             input_input_switch3_shift_en_3,
  input  logic             input_input_switch4_serial_in_4,
  input  logic             input_input_switch5_ack_5,
  output logic [WIDTH-1:0] output_led1_data_6,
  output logic             output_led2_valid_7,
  output logic             output_led3_overrun_8,
  output logic             output_led4_busy_9
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_overrun;

  logic [WIDTH-1:0] w_word;
  logic             w_last;
  logic             w_complete;

  assign w_word     = {r_sr[WIDTH-2:0], input_input_switch4_serial_in_4};
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_complete = input_input_switch3_shift_en_3 && (r_state == S_SHIFT) && w_last;

  // Handshake: valid rises when a completed word is loaded and stays high until an
  // edge with ack=1; ack with valid=0 is ignored; a word completing while valid=1
  // and ack=0 is dropped and sets the sticky overrun flag instead of overwriting data.
  always_ff @(posedge input_input_switch1_clock_1) begin
    if (input_input_switch2_reset_2) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_sr      <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (input_input_switch3_shift_en_3) begin
        r_sr <= w_word;
        if (w_complete) begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end else begin
          r_cnt   <= r_cnt + CNT_W'(1);
          r_state <= S_SHIFT;
        end
      end else begin
        // Gap in framing abandons any partial word without flagging it.
        r_cnt   <= '0;
        r_state <= S_IDLE;
      end

      if (w_complete) begin
        if (!r_valid || input_input_switch5_ack_5) begin
          r_data  <= w_word;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (input_input_switch5_ack_5 && r_valid) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign output_led1_data_6    = r_data;
  assign output_led2_valid_7   = r_valid;
  assign output_led3_overrun_8 = r_overrun;
  assign output_led4_busy_9    = (r_state == S_SHIFT);

endmodule

// File: tb/tb_deserialize.sv
// Bench for deserialize: directed scenarios plus randomized framing/ack traffic,
// checked against a bit-queue reference model and a word scoreboard.
module tb_deserialize;
  localparam int WIDTH = 4;
  localparam int CNT_W = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic shift_en = 1'b0;
  logic serial = 1'b0;
  logic ack = 1'b0;
  logic [WIDTH-1:0] data;
  logic valid, overrun, busy;

  always #5 clk = ~clk;

  deserialize #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .input_input_switch1_clock_1    (clk),
    .input_input_switch2_reset_2    (rst),
    .input_input_switch3_shift_en_3 (shift_en),
    .input_input_switch4_serial_in_4(serial),
    .input_input_switch5_ack_5      (ack),
    .output_led1_data_6             (data),
    .output_led2_valid_7            (valid),
    .output_led3_overrun_8          (overrun),
    .output_led4_busy_9             (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: bits of the current word kept in a queue
  logic [WIDTH-1:0] exp_q[$];
  logic bits_q[$];
  logic m_valid = 1'b0;
  logic m_overrun = 1'b0;
  logic [WIDTH-1:0] m_data = '0;

  always @(posedge clk) begin
    int word;
    logic got;
    if (rst) begin
      bits_q.delete();
      exp_q.delete();
      m_valid = 1'b0;
      m_overrun = 1'b0;
      m_data = '0;
    end else begin
      got = 1'b0;
      word = 0;
      if (shift_en) begin
        bits_q.push_back(serial);
        if (bits_q.size() == WIDTH) begin
          foreach (bits_q[i]) word = word * 2 + int'(bits_q[i]);
          bits_q.delete();
          got = 1'b1;
        end
      end else begin
        bits_q.delete();
      end
      if (got) begin
        if (!m_valid || ack) begin
          m_data = word[WIDTH-1:0];
          m_valid = 1'b1;
          exp_q.push_back(word[WIDTH-1:0]);
        end else begin
          m_overrun = 1'b1;
        end
      end else if (ack && m_valid) begin
        m_valid = 1'b0;
      end
    end
  end

  // monitor / consumer: status checks and ack decisions on the falling edge
  int   ack_mode = 0;  // 0: only on request, 1: always, 2: random
  logic ack_req = 1'b0;

  initial begin
    forever begin
      logic do_ack;
      @(negedge clk);
      check("valid", {31'd0, valid}, {31'd0, m_valid});
      check("busy", {31'd0, busy}, {31'd0, logic'(bits_q.size() != 0)});
      check("overrun", {31'd0, overrun}, {31'd0, m_overrun});
      check("data", {28'd0, data}, {28'd0, m_data});
      do_ack = ack_req || (ack_mode == 1) || (ack_mode == 2 && $urandom_range(1, 0) == 1);
      if (do_ack && m_valid) begin
        if (exp_q.size() == 0) check("word_pending", 32'd0, 32'd1);
        else check("word", {28'd0, data}, {28'd0, exp_q.pop_front()});
      end
      ack = do_ack;
    end
  end

  // driver tasks: inputs change just after the rising edge
  task automatic send(input logic sh, input logic b, input logic a);
    shift_en = sh;
    serial = b;
    ack_req = a;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input logic ack_last);
    logic [WIDTH-1:0] v;
    v = w;
    for (int i = WIDTH - 1; i >= 0; i--) send(1'b1, v[i], (i == 0) ? ack_last : 1'b0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) send(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    #1;
    // T1 reset
    do_reset(2);
    check("t1_data", {28'd0, data}, 32'd0);
    check("t1_valid", {31'd0, valid}, 32'd0);
    check("t1_overrun", {31'd0, overrun}, 32'd0);
    check("t1_busy", {31'd0, busy}, 32'd0);
    send(1'b0, 1'b0, 1'b0);

    // T2 basic word then ack
    send_word(4'b1011, 1'b0);
    check("t2_data", {28'd0, data}, 32'hB);
    check("t2_valid", {31'd0, valid}, 32'd1);
    check("t2_busy", {31'd0, busy}, 32'd0);
    send(1'b0, 1'b0, 1'b1);
    check("t2_ack_valid", {31'd0, valid}, 32'd0);
    check("t2_ack_data", {28'd0, data}, 32'hB);

    // T3 abort mid-word
    send(1'b1, 1'b1, 1'b0);
    send(1'b1, 1'b1, 1'b0);
    check("t3_busy_mid", {31'd0, busy}, 32'd1);
    send(1'b0, 1'b0, 1'b0);
    check("t3_busy_abort", {31'd0, busy}, 32'd0);
    send_word(4'b0110, 1'b0);
    check("t3_data", {28'd0, data}, 32'h6);
    check("t3_valid", {31'd0, valid}, 32'd1);

    // T4 overrun
    do_reset(1);
    send_word(4'b1010, 1'b0);
    send_word(4'b0101, 1'b0);
    check("t4_data", {28'd0, data}, 32'hA);
    check("t4_valid", {31'd0, valid}, 32'd1);
    check("t4_overrun", {31'd0, overrun}, 32'd1);
    send(1'b0, 1'b0, 1'b1);
    check("t4_ack_valid", {31'd0, valid}, 32'd0);
    send(1'b0, 1'b0, 1'b0);
    check("t4_sticky", {31'd0, overrun}, 32'd1);

    // T5 ack on the completing edge
    do_reset(1);
    send_word(4'b1010, 1'b0);
    check("t5_hold", {28'd0, data}, 32'hA);
    send_word(4'b0011, 1'b1);
    check("t5_data", {28'd0, data}, 32'h3);
    check("t5_valid", {31'd0, valid}, 32'd1);
    check("t5_overrun", {31'd0, overrun}, 32'd0);

    // T6 reset mid-word
    do_reset(1);
    send(1'b1, 1'b1, 1'b0);
    send(1'b1, 1'b0, 1'b0);
    do_reset(1);
    check("t6_busy", {31'd0, busy}, 32'd0);
    send_word(4'b1100, 1'b0);
    check("t6_data", {28'd0, data}, 32'hC);
    check("t6_valid", {31'd0, valid}, 32'd1);

    // randomized traffic with random consumer
    do_reset(1);
    ack_mode = 2;
    for (int i = 0; i < 400; i++)
      send(1'($urandom_range(7, 0) != 0), 1'($urandom_range(1, 0)), 1'b0);
    ack_mode = 1;
    for (int i = 0; i < 4; i++) send(1'b0, 1'b0, 1'b0);
    check("drain_empty", exp_q.size(), 32'd0);
    check("drain_valid", {31'd0, valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
